// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_t;

    // {R,G,B} enables for bars 0..7, left to right.
    localparam logic [2:0] BAR_MASK [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counter over active/front/sync/back with region decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 800,
    parameter int FRONT  = 40,
    parameter int SYNC   = 128,
    parameter int BACK   = 88,
    parameter bit POL    = 1'b1,
    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK),
    localparam int CW    = $clog2(TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          active,
    output logic          sync
);

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FRONT);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FRONT + SYNC - 1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (advance)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

    assign wrap   = advance && (cnt == LAST);
    assign active = (cnt < ACT_END);
    assign sync   = (cnt >= SYNC_FIRST && cnt <= SYNC_LAST) ? POL : !POL;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with frame-synchronous selectable RGB test patterns.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int WIDTH      = 800,
    parameter int HEIGHT     = 600,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter bit H_POL      = 1'b1,
    parameter bit V_POL      = 1'b1,
    parameter int COLOR_W    = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  mode,
    input  logic [3*COLOR_W-1:0]        color,
    output logic                        h_sync,
    output logic                        v_sync,
    output logic                        de,
    output logic [3*COLOR_W-1:0]        data,
    output logic [$clog2(WIDTH)-1:0]    x,
    output logic [$clog2(HEIGHT)-1:0]   y,
    output logic                        frame,
    output logic                        line
);

    localparam int H_TOTAL = axis_total(WIDTH, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(HEIGHT, V_FRONT, V_SYNC, V_BACK);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int XW      = $clog2(WIDTH);
    localparam int YW      = $clog2(HEIGHT);
    localparam int PW      = 3 * COLOR_W;
    localparam int BAR_W   = WIDTH / 8;
    localparam int BPW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           h_wrap, v_wrap;
    logic           h_active, v_active;
    logic           h_sync_c, v_sync_c;

    vga_axis_counter #(
        .ACTIVE(WIDTH), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_POL)
    ) u_h_axis (
        .clk(clk), .reset(reset), .advance(1'b1),
        .cnt(h_cnt), .wrap(h_wrap), .active(h_active), .sync(h_sync_c)
    );

    vga_axis_counter #(
        .ACTIVE(HEIGHT), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_POL)
    ) u_v_axis (
        .clk(clk), .reset(reset), .advance(h_wrap),
        .cnt(v_cnt), .wrap(v_wrap), .active(v_active), .sync(v_sync_c)
    );

    // The vertical wrap is the last cycle of the frame: inputs latch only here.
    mode_t          cur_mode;
    logic [PW-1:0]  cur_color;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_mode  <= MODE_SOLID;
            cur_color <= '0;
        end else if (v_wrap) begin
            cur_mode  <= mode_t'(mode);
            cur_color <= color;
        end
    end

    // Bar index tracks h_cnt without a divider; the last bar soaks up the remainder.
    logic [2:0]     bar_idx;
    logic [BPW-1:0] bar_pix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_idx <= '0;
            bar_pix <= '0;
        end else if (h_wrap) begin
            bar_idx <= '0;
            bar_pix <= '0;
        end else if (bar_pix == BAR_LAST) begin
            bar_pix <= '0;
            if (bar_idx != 3'd7)
                bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_pix <= bar_pix + 1'b1;
        end
    end

    logic               pix_active;
    logic [PW-1:0]      pix_data;
    logic [COLOR_W-1:0] ramp;
    logic [2:0]         mask;

    assign pix_active = h_active && v_active;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pix_data = '0;
        ramp     = COLOR_W'(h_cnt);
        mask     = BAR_MASK[bar_idx];
        if (pix_active) begin
            case (cur_mode)
                MODE_SOLID: pix_data = cur_color;
                MODE_GRAD:  pix_data = {3{ramp}};
                MODE_BARS:  pix_data = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
                MODE_CHECK: pix_data = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? '1 : '0;
                default:    pix_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_sync <= !H_POL;
            v_sync <= !V_POL;
            de     <= 1'b0;
            data   <= '0;
            x      <= '0;
            y      <= '0;
            frame  <= 1'b0;
            line   <= 1'b0;
        end else begin
            h_sync <= h_sync_c;
            v_sync <= v_sync_c;
            de     <= pix_active;
            data   <= pix_data;
            x      <= pix_active ? XW'(h_cnt) : '0;
            y      <= pix_active ? YW'(v_cnt) : '0;
            frame  <= (h_cnt == '0) && (v_cnt == '0);
            line   <= (h_cnt == '0) && v_active;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen at small timing (16x8, H 2/3/2, V 1/2/1).
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode = 2'd0;
    logic [23:0] color = 24'h0;
    logic        h_sync, v_sync, de, frame, line;
    logic [23:0] data;
    logic [3:0]  x;
    logic [2:0]  y;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .WIDTH(16), .HEIGHT(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .H_POL(1'b1), .V_POL(1'b0),
        .COLOR_W(8), .CHECK_LOG2(2)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .color(color),
        .h_sync(h_sync), .v_sync(v_sync), .de(de), .data(data),
        .x(x), .y(y), .frame(frame), .line(line)
    );

    typedef struct {
        int          frm;
        int          px;
        int          py;
        logic [23:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   frame_no = 0;
    int   blank_bad = 0;

    // Hand-derived bar colours for bar 0..7.
    logic [23:0] bar_exp [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int f, input int px, input int py, input logic [23:0] v);
        exp_t e;
        e.frm = f; e.px = px; e.py = py; e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_reset_state();
        check("rst_h_sync", h_sync, 0);
        check("rst_v_sync", v_sync, 1);
        check("rst_de", de, 0);
        check("rst_data", data, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_frame", frame, 0);
        check("rst_line", line, 0);
    endtask

    task automatic check_first_pixel();
        check("first_frame", frame, 1);
        check("first_line", line, 1);
        check("first_de", de, 1);
        check("first_x", x, 0);
        check("first_y", y, 0);
        check("first_data", data, 0);
        check("first_h_sync", h_sync, 0);
        check("first_v_sync", v_sync, 1);
    endtask

    task automatic wait_frame(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (frame === 1'b1) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    // Monitor: timing measurements plus scoreboard pops on matching active pixels.
    initial begin
        int cyc = 0, last_frame = 0, line_cnt = 0, de_total = 0, last_line = 0;
        int de_rise = 0, run = 0, hs_start = 0, vs_start = 0;
        bit have_frame = 0, have_line = 0, have_rise = 0, have_hs = 0, have_vs = 0;
        bit prev_de = 0, prev_hs = 0, prev_vs = 1;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                have_frame = 0; have_line = 0; have_rise = 0; have_hs = 0; have_vs = 0;
                prev_de = 0; prev_hs = 0; prev_vs = 1; run = 0;
            end else begin
                if (frame) begin
                    frame_no++;
                    if (have_frame) begin
                        check("frame_period", cyc - last_frame, 276);
                        check("lines_per_frame", line_cnt, 8);
                        check("de_per_frame", de_total, 128);
                    end
                    have_frame = 1; last_frame = cyc; line_cnt = 0; de_total = 0; have_line = 0;
                end
                if (line) begin
                    if (have_line) check("line_spacing", cyc - last_line, 23);
                    have_line = 1; last_line = cyc; line_cnt++;
                end
                if (de && !prev_de) begin
                    de_rise = cyc; have_rise = 1; run = 0;
                end
                if (de) begin
                    run++; de_total++;
                end
                if (!de && prev_de) check("de_run", run, 16);
                if (!de && (data != 0 || x != 0 || y != 0)) blank_bad++;
                if (h_sync && !prev_hs) begin
                    if (have_rise && (cyc - de_rise) < 23) check("hsync_after_de", cyc - de_rise, 18);
                    hs_start = cyc; have_hs = 1;
                end
                if (!h_sync && prev_hs && have_hs) check("hsync_width", cyc - hs_start, 3);
                if (!v_sync && prev_vs) begin
                    if (have_frame) check("vsync_start", cyc - last_frame, 207);
                    vs_start = cyc; have_vs = 1;
                end
                if (v_sync && !prev_vs && have_vs) check("vsync_width", cyc - vs_start, 46);
                if (de && sb.size() > 0) begin
                    if (sb[0].frm == frame_no && sb[0].px == int'(x) && sb[0].py == int'(y)) begin
                        e = sb.pop_front();
                        check($sformatf("pix_f%0d_x%0d_y%0d", e.frm, e.px, e.py), data, e.val);
                    end
                end
                prev_de = de; prev_hs = h_sync; prev_vs = v_sync;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state();
        #1 reset = 1'b0;
        @(negedge clk);
        check_first_pixel();

        // Frame 1 stays black even though inputs change mid-frame.
        push_exp(1, 3, 3, 24'h000000);
        push_exp(1, 15, 7, 24'h000000);
        push_exp(2, 0, 0, 24'hFF8000);
        push_exp(2, 7, 4, 24'hFF8000);
        push_exp(2, 15, 7, 24'hFF8000);
        repeat (60) @(negedge clk);
        mode  = 2'd0;
        color = 24'hFF8000;

        wait_frame("wait_frame2");
        repeat (30) @(negedge clk);
        mode = 2'd2;
        for (int i = 0; i < 16; i++) push_exp(3, i, 2, bar_exp[i / 2]);

        wait_frame("wait_frame3");
        repeat (30) @(negedge clk);
        mode = 2'd3;
        push_exp(4, 0, 0, 24'h000000);
        push_exp(4, 4, 0, 24'hFFFFFF);
        push_exp(4, 0, 4, 24'hFFFFFF);
        push_exp(4, 4, 4, 24'h000000);

        wait_frame("wait_frame4");
        repeat (30) @(negedge clk);
        mode = 2'd1;
        push_exp(5, 15, 0, 24'h0F0F0F);
        push_exp(5, 5, 1, 24'h050505);

        // Present bars only during the frame-wrap cycle; it must still be captured.
        wait_frame("wait_frame5");
        repeat (274) @(negedge clk);
        mode = 2'd2;
        @(negedge clk);
        mode = 2'd1;
        push_exp(6, 0, 1, 24'hFFFFFF);
        push_exp(6, 5, 1, 24'h00FFFF);
        push_exp(6, 14, 1, 24'h000000);

        wait_frame("wait_frame6");
        repeat (74) @(negedge clk);
        check("pre_reset_x", x, 5);
        check("pre_reset_y", y, 3);
        #1 reset = 1'b1;
        #1 check_reset_state();
        repeat (2) @(negedge clk);
        check_reset_state();
        #1 reset = 1'b0;
        @(negedge clk);
        check_first_pixel();
        push_exp(7, 3, 2, 24'h000000);
        push_exp(7, 9, 6, 24'h000000);
        push_exp(8, 9, 6, 24'h090909);

        wait_frame("wait_frame8");
        wait_frame("wait_frame9");
        @(negedge clk);
        check("frames_seen", frame_no, 9);
        check("scoreboard_drained", sb.size(), 0);
        check("blank_zero", blank_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised successor to the VGA frame generator. It produces horizontal/vertical timing with configurable sync polarity and a registered RGB test pattern. Four pattern modes are available: solid, gradient, colour bars and checkerboard. Mode and solid colour are selected at runtime and take effect only on frame boundaries. The block sits between the pixel-clock domain and the video DAC/HDMI encoder, and replaces the fixed x-ramp generator.

## Interface
Parameters:
- WIDTH, 800: active pixels per line.
- HEIGHT, 600: active lines per frame.
- H_FRONT / H_SYNC / H_BACK, 40 / 128 / 88: horizontal porch and sync widths, in pixels.
- V_FRONT / V_SYNC / V_BACK, 1 / 4 / 23: vertical porch and sync widths, in lines.
- H_POL, 1: active level of h_sync.
- V_POL, 1: active level of v_sync.
- COLOR_W, 8: bits per colour channel.
- CHECK_LOG2, 5: checker square size is 2^CHECK_LOG2 pixels.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock.
- reset  in  1  async active-high reset.
- mode  in  2  pattern select: 0 solid, 1 gradient, 2 colour bars, 3 checker.
- color  in  3*COLOR_W  solid colour, packed {R,G,B}.
- h_sync  out  1  horizontal sync.
- v_sync  out  1  vertical sync.
- de  out  1  data enable (active region).
- data  out  3*COLOR_W  pixel, packed {R,G,B}.
- x  out  $clog2(WIDTH)  active column.
- y  out  $clog2(HEIGHT)  active line.
- frame  out  1  one-cycle pulse on pixel (0,0).
- line  out  1  one-cycle pulse on column 0 of every active line.

## Operation
Counters:
- Internal h_cnt runs 0..H_TOTAL-1, where H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK.
- Internal v_cnt runs 0..V_TOTAL-1 and advances when h_cnt wraps.
- Both wrap to 0. Line order is: active, front porch, sync, back porch.

Region decode:
- Active when h_cnt<WIDTH and v_cnt<HEIGHT.
- h_sync = H_POL for h_cnt in [WIDTH+H_FRONT, WIDTH+H_FRONT+H_SYNC-1], else !H_POL.
- v_sync = V_POL for whole lines with v_cnt in [HEIGHT+V_FRONT, HEIGHT+V_FRONT+V_SYNC-1], else !V_POL.

Shadow registers:
- cur_mode and cur_color load from mode/color in the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
- Changes on the inputs at any other time are ignored until the next frame.

Patterns (active region only; data=0 whenever de=0):
- Solid: data = cur_color.
- Gradient: every channel = h_cnt[COLOR_W-1:0], grey ramp that wraps.
- Colour bars:
  - 8 bars, each BAR_W=WIDTH/8 pixels wide. The last bar absorbs the remainder.
  - The bar index comes from a bar counter reset at h_cnt=0 and stepped every BAR_W pixels, saturating at 7. No divider.
  - Bar index 0..7 maps to RGB masks 111,110,011,010,101,100,001,000. Each mask bit drives its channel all-ones or zero.
- Checker: white when h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2] is 1, else black.

Output qualification:
- x = h_cnt and y = v_cnt when active; x = 0 and y = 0 otherwise.
- frame = 1 iff h_cnt=0 and v_cnt=0.
- line = 1 iff h_cnt=0 and v_cnt<HEIGHT.

## Timing
- All outputs are registered and mutually aligned, with one cycle latency from counter state to output.
- Reset values:
  - h_cnt, v_cnt and bar counter: 0.
  - cur_mode = 0, cur_color = 0.
  - h_sync = !H_POL, v_sync = !V_POL.
  - de, data, x, y, frame, line: 0.
- First edge after reset release: outputs show pixel (0,0) with de=1, frame=1, line=1 and data=0. The first frame is solid black.
- Frame period is exactly H_TOTAL*V_TOTAL cycles.
  - frame pulses every H_TOTAL*V_TOTAL cycles.
  - line pulses HEIGHT times per frame, H_TOTAL cycles apart.
- de is high for exactly WIDTH consecutive cycles per active line and is never high on blank lines.
- Reset asserted mid-frame: all outputs go to reset values immediately (async). Restart is at (0,0).
- A mode change and the frame wrap in the same cycle: the new value is captured and applies to the very next pixel (0,0).

## Structure
- Package vga_pkg holds:
  - the mode_t enum (MODE_SOLID, MODE_GRAD, MODE_BARS, MODE_CHECK);
  - the 8-entry bar RGB-mask constant;
  - a function computing totals from porch parameters.
- One natural sub-module, vga_axis_counter, is instantiated twice (horizontal, vertical). It has parameters ACTIVE/FRONT/SYNC/BACK/POL, an advance input, and outputs cnt, wrap, active and sync.

## Test plan
Small timing is WIDTH=16, HEIGHT=8, H 2/3/2, V 1/2/1, which gives H_TOTAL=23 and V_TOTAL=12.
- Reset then free-run at small timing:
  - frame pulses every 276 cycles;
  - 8 line pulses per frame, 23 cycles apart;
  - de high for 16 cycles per line;
  - h_sync low for exactly 3 cycles, starting 18 cycles after de rises (POL=0 run).
- Sync polarity: H_POL=1, V_POL=0 → h_sync high for 3 cycles per line; v_sync low for 2 full lines (46 cycles) starting 9 lines after frame.
- mode=0, color=0xFF8000, applied mid-frame → remainder of current frame unchanged; every active pixel of the next frame = 0xFF8000; blanking data = 0.
- mode=2 at WIDTH=16 → bars 2 pixels wide. Pixels 0..15 of each line read FFFFFF, FFFFFF, FFFF00, FFFF00, 00FFFF, ... ending 000000 at x=14,15.
- mode=3, CHECK_LOG2=2 → (x=0,y=0) black; (x=4,y=0) white; (x=4,y=4) black.
- Assert reset at pixel (5,3) for 2 cycles → outputs go to reset values asynchronously; the first edge after release shows frame=1 and x=0,y=0; cur_mode is back to solid black.
